// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared FSM state encoding and stream constants for the UART image loader
package uart_loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN, DATA, FIN, ERR} state_e;

    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs popped bytes little-endian into 32-bit words, flags the 4th byte
module uart_word_assembler
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  idx_q;
    logic [31:0] lane_q, lane_d;

    // Merge the incoming byte into its lane so the full word is visible on the completing pop
    always_comb begin
        lane_d = lane_q;
        lane_d[{idx_q, 3'b000} +: 8] = byte_i;
    end

    assign word_o       = lane_d;
    assign word_ready_o = push_i && (idx_q == 2'(LEN_BYTES - 1));

    // Byte index and lane register advance only on a pop; clear restarts a fresh word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q  <= '0;
            lane_q <= '0;
        end else if (clr_i) begin
            idx_q  <= '0;
            lane_q <= '0;
        end else if (push_i) begin
            idx_q  <= idx_q + 1'b1;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: drains the UART RX FIFO and writes a length-prefixed image into word memory
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              rx_empty,
    input  logic [7:0]        rx_dout,
    output logic              rx_rd_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] CAP = 32'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              clr;
    logic [31:0]       word;
    logic              word_ready;

    assign clr       = (state_q == IDLE) && start;
    assign rx_rd_en  = ((state_q == LEN) || (state_q == DATA)) && !rx_empty;
    assign busy      = state_q != IDLE;
    assign done      = state_q == FIN;
    assign err       = err_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    uart_word_assembler u_asm (
        .clk          (clk),
        .rstn         (rstn),
        .clr_i        (clr),
        .push_i       (rx_rd_en),
        .byte_i       (rx_dout),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    // Next-state: length check on the 4th length byte, one write per completed data word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LEN;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            LEN: if (word_ready) begin
                len_d   = word[ADDR_W:0];
                err_d   = word > CAP;
                state_d = (word == 32'd0) ? FIN : (word > CAP) ? ERR : DATA;
            end
            DATA: if (word_ready) begin
                we_d    = 1'b1;
                wdata_d = word;
                addr_d  = cnt_q[ADDR_W-1:0];
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_d == len_q) ? FIN : DATA;
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any partial load immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed scenarios for the UART image loader with a byte-queue FIFO model
module tb_uart_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn, start, rx_empty;
    logic [7:0]    rx_dout;
    logic          rx_rd_en, mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    int vectors = 0, miscompares = 0;

    logic [7:0]    q[$];
    logic [AW-1:0] waddr[$];
    logic [31:0]   wdata[$];
    int cyc = 0, start_cyc, n_pops, n_done, done_cyc, err_cyc;
    bit done_with_we, bad_pop, tmo, busy_at_start, err_at_start;

    always #5 clk = ~clk;

    uart_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .rx_empty  (rx_empty),
        .rx_dout   (rx_dout),
        .rx_rd_en  (rx_rd_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic clear_log();
        n_pops = 0; n_done = 0; done_cyc = -1; err_cyc = -1;
        done_with_we = 0; bad_pop = 0; tmo = 0;
        waddr.delete(); wdata.delete();
    endtask

    task automatic step(input bit st, input bit gap);
        bit pop;
        @(negedge clk);
        start    = st;
        rx_empty = gap || (q.size() == 0);
        rx_dout  = rx_empty ? 8'h00 : q[0];
        #1;
        pop = rx_rd_en;
        if (rx_rd_en && rx_empty) bad_pop = 1;
        @(posedge clk);
        if (pop) begin q.delete(0); n_pops++; end
        #1;
        cyc++;
        if (mem_we) begin waddr.push_back(mem_addr); wdata.push_back(mem_wdata); end
        if (done) begin n_done++; done_cyc = cyc; done_with_we = mem_we; end
        if (err && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic run_load(input bit gaps);
        clear_log();
        step(1, 0);
        start_cyc     = cyc;
        busy_at_start = busy;
        err_at_start  = err;
        for (int i = 0; i < 400; i++) begin
            step(0, gaps && (i % 2 == 0));
            if (!busy) return;
        end
        tmo = 1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({rx_rd_en, mem_we, mem_addr, mem_wdata, busy, done, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h busy=%b done=%b err=%b, want all 0", mem_we, mem_addr, mem_wdata, busy, done, err);
        end
        @(negedge clk); rstn = 1'b1;
        clear_log();
        step(0, 0);
        vectors++;
        if ({busy, done, err, mem_we} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b done=%b err=%b we=%b, want 0", busy, done, err, mem_we);
        end
    endtask

    task automatic test_basic();
        q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(0);
        vectors++;
        if ({tmo, busy_at_start} !== 2'b01) begin miscompares++; $display("FAIL basic_start: got tmo=%b busy=%b, want 0 1", tmo, busy_at_start); end
        vectors++;
        if (waddr.size() != 2) begin miscompares++; $display("FAIL basic_nwrites: got %0d want 2", waddr.size()); end
        else begin
            vectors++;
            if ({waddr[0], wdata[0], waddr[1], wdata[1]} !== {4'd0, 32'h12345678, 4'd1, 32'hDEADBEEF}) begin
                miscompares++;
                $display("FAIL basic_writes: got %h:%h %h:%h want 0:12345678 1:deadbeef", waddr[0], wdata[0], waddr[1], wdata[1]);
            end
        end
        vectors++;
        if ({n_done, done_with_we} !== {32'd1, 1'b1}) begin miscompares++; $display("FAIL basic_done: got n=%0d with_we=%b want 1 1", n_done, done_with_we); end
        vectors++;
        if (done_cyc != start_cyc + 12 || done_cyc != cyc - 1) begin
            miscompares++;
            $display("FAIL basic_done_timing: got done@%0d idle@%0d want done@%0d idle@%0d", done_cyc, cyc, start_cyc + 12, start_cyc + 13);
        end
        vectors++;
        if ({mem_we, mem_wdata, err, n_pops} !== {1'b0, 32'hDEADBEEF, 1'b0, 32'd12}) begin
            miscompares++;
            $display("FAIL basic_after: got we=%b wdata=%h err=%b pops=%0d want 0 deadbeef 0 12", mem_we, mem_wdata, err, n_pops);
        end
    endtask

    task automatic test_gaps();
        q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(1);
        vectors++;
        if ({tmo, bad_pop} !== 2'b00) begin miscompares++; $display("FAIL gaps_pop_empty: got tmo=%b bad_pop=%b want 0 0", tmo, bad_pop); end
        vectors++;
        if (waddr.size() != 2) begin miscompares++; $display("FAIL gaps_nwrites: got %0d want 2", waddr.size()); end
        else begin
            vectors++;
            if ({waddr[0], wdata[0], waddr[1], wdata[1]} !== {4'd0, 32'h12345678, 4'd1, 32'hDEADBEEF}) begin
                miscompares++;
                $display("FAIL gaps_writes: got %h:%h %h:%h want 0:12345678 1:deadbeef", waddr[0], wdata[0], waddr[1], wdata[1]);
            end
        end
        vectors++;
        if ({n_done, done_with_we} !== {32'd1, 1'b1}) begin miscompares++; $display("FAIL gaps_done: got n=%0d with_we=%b want 1 1", n_done, done_with_we); end
    endtask

    task automatic test_len_zero();
        q = {8'h00, 8'h00, 8'h00, 8'h00};
        run_load(0);
        vectors++;
        if (waddr.size() != 0) begin miscompares++; $display("FAIL len0_writes: got %0d want 0", waddr.size()); end
        vectors++;
        if (n_done != 1 || done_cyc != start_cyc + 4 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_done: got n=%0d @%0d err=%b want 1 @%0d err=0", n_done, done_cyc, err, start_cyc + 4);
        end
    endtask

    task automatic test_len_err();
        q = {8'h11, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(0);
        vectors++;
        if (err_cyc != start_cyc + 4 || cyc != start_cyc + 5) begin
            miscompares++;
            $display("FAIL err_timing: got err@%0d idle@%0d want err@%0d idle@%0d", err_cyc, cyc, start_cyc + 4, start_cyc + 5);
        end
        vectors++;
        if (n_pops != 4 || q.size() != 4) begin miscompares++; $display("FAIL err_pops: got pops=%0d left=%0d want 4 4", n_pops, q.size()); end
        vectors++;
        if (waddr.size() != 0 || n_done != 0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_state: got writes=%0d done=%0d err=%b want 0 0 1", waddr.size(), n_done, err);
        end
        step(0, 0);
        vectors++;
        if ({err, busy} !== 2'b10) begin miscompares++; $display("FAIL err_sticky: got err=%b busy=%b want 1 0", err, busy); end
        q.delete();
    endtask

    task automatic test_full();
        q = {8'h10, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 16; k++) q = {q, 8'(k), 8'h11, 8'h22, 8'hA0};
        run_load(0);
        vectors++;
        if ({tmo, err_at_start} !== 2'b00) begin miscompares++; $display("FAIL full_err_cleared: got tmo=%b err=%b want 0 0", tmo, err_at_start); end
        vectors++;
        if (waddr.size() != 16) begin miscompares++; $display("FAIL full_nwrites: got %0d want 16", waddr.size()); end
        else for (int k = 0; k < 16; k++) begin
            vectors++;
            if ({waddr[k], wdata[k]} !== {4'(k), 32'hA0221100 | k}) begin
                miscompares++;
                $display("FAIL full_write%0d: got %h:%h want %h:%h", k, waddr[k], wdata[k], 4'(k), 32'hA0221100 | k);
            end
        end
        vectors++;
        if (n_done != 1 || err !== 1'b0) begin miscompares++; $display("FAIL full_done: got n=%0d err=%b want 1 0", n_done, err); end
    endtask

    task automatic test_reset_mid();
        q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_log();
        step(1, 0);
        for (int i = 0; i < 50 && n_pops < 10; i++) step(0, 0);
        vectors++;
        if ({n_pops, busy, mem_wdata} !== {32'd10, 1'b1, 32'h12345678}) begin
            miscompares++;
            $display("FAIL mid_pre: got pops=%0d busy=%b wdata=%h want 10 1 12345678", n_pops, busy, mem_wdata);
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({rx_rd_en, mem_we, mem_addr, mem_wdata, busy, done, err} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got rd=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b want all 0", rx_rd_en, mem_we, mem_addr, mem_wdata, busy, done, err);
        end
        #2 rstn = 1'b1;
        q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        run_load(0);
        vectors++;
        if (waddr.size() != 1) begin miscompares++; $display("FAIL restart_nwrites: got %0d want 1", waddr.size()); end
        else begin
            vectors++;
            if ({waddr[0], wdata[0], n_done} !== {4'd0, 32'h11223344, 32'd1}) begin
                miscompares++;
                $display("FAIL restart_write: got %h:%h done=%0d want 0:11223344 1", waddr[0], wdata[0], n_done);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; rx_empty = 1'b1; rx_dout = 8'h00;
        test_reset();
        test_basic();
        test_gaps();
        test_len_zero();
        test_len_err();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
